// File: rtl/uart_msg_pkg.sv
// Shared types and helpers for the UART message scheduler.
// State encoding, terminator default and slot address math.
package uart_msg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CHECK,
    SEND,
    WAIT_DONE,
    DONE
  } state_e;

  localparam logic [7:0] TERM_DEF = 8'h00;

  function automatic int slot_base(input int id, input int slot_len);
    return id * slot_len;
  endfunction

endpackage

// File: rtl/uart_msg_scheduler_rr_arbiter.sv
// Round-robin pick: first pending index at or after rr_ptr, wrapping.
// Purely combinational; the caller owns the pointer.
module rr_arbiter
  import uart_msg_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               valid
);

  int           s;
  logic [IDW-1:0] sel;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    s     = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      sel = IDW'(s);
      if (!valid && pending[sel]) begin
        valid    = 1'b1;
        idx      = sel;
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Shares one ROM and one UART TX among NUM_REQ message slots.
// Walks the granted slot byte by byte until TERM or slot end.
module uart_msg_scheduler
  import uart_msg_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 128,
  parameter int SLOT_LEN = 32,
  parameter int ADDR     = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] TERM = WIDTH'(TERM_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [ADDR-1:0]    rom_addr,
  input  logic [WIDTH-1:0]   rom_data,
  output logic [WIDTH-1:0]   uart_data,
  output logic               uart_data_valid,
  input  logic               uart_busy,
  input  logic               uart_tx_done,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] msg_done,
  output logic               busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(SLOT_LEN + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] msg_done_q, msg_done_d;
  logic [ADDR-1:0]    rom_addr_q, rom_addr_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [WIDTH-1:0]   uart_data_q, uart_data_d;
  logic               valid_q, valid_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_idx;
  logic               arb_valid;
  logic [CW-1:0]      cnt_inc;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDW    (IDW)
  ) u_arb (
    .pending(pending_q),
    .rr_ptr (rr_ptr_q),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign cnt_inc = byte_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | req;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    grant_d     = grant_q;
    msg_done_d  = '0;
    rom_addr_d  = rom_addr_q;
    byte_cnt_d  = byte_cnt_q;
    uart_data_d = uart_data_q;
    valid_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          // a req on the same bit this cycle survives the clear
          pending_d  = (pending_q & ~arb_gnt) | req;
          cur_id_d   = arb_idx;
          grant_d    = arb_gnt;
          rom_addr_d = ADDR'(slot_base(int'(arb_idx), SLOT_LEN));
          byte_cnt_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        if (rom_data == TERM) begin
          state_d = DONE;
        end else begin
          uart_data_d = rom_data;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!uart_busy) begin
          valid_d = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          byte_cnt_d = cnt_inc;
          if (cnt_inc == CW'(SLOT_LEN)) begin
            state_d = DONE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR'(1);
            state_d    = FETCH;
          end
        end
      end
      DONE: begin
        msg_done_d = grant_q;
        grant_d    = '0;
        rr_ptr_d   = (cur_id_q == IDW'(NUM_REQ - 1)) ? '0
                                                     : cur_id_q + IDW'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      grant_q     <= '0;
      msg_done_q  <= '0;
      rom_addr_q  <= '0;
      byte_cnt_q  <= '0;
      uart_data_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      grant_q     <= grant_d;
      msg_done_q  <= msg_done_d;
      rom_addr_q  <= rom_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      uart_data_q <= uart_data_d;
      valid_q     <= valid_d;
    end
  end

  assign rom_addr        = rom_addr_q;
  assign uart_data       = uart_data_q;
  assign uart_data_valid = valid_q;
  assign grant           = grant_q;
  assign msg_done        = msg_done_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Bench for uart_msg_scheduler: ROM and UART models plus a
// scoreboard of expected bytes/completions in service order.
module tb_uart_msg_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       uart_busy;
  logic       uart_tx_done = 1'b0;
  logic [3:0] grant;
  logic [3:0] msg_done;
  logic       busy;

  uart_msg_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .uart_data      (uart_data),
    .uart_data_valid(uart_data_valid),
    .uart_busy      (uart_busy),
    .uart_tx_done   (uart_tx_done),
    .grant          (grant),
    .msg_done       (msg_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_img [128];
  always @(posedge clk) rom_data <= rom_img[rom_addr];

  logic mbusy     = 1'b0;
  logic hold_busy = 1'b0;
  int   mcnt      = 0;
  assign uart_busy = mbusy | hold_busy;
  always @(posedge clk) begin
    uart_tx_done <= 1'b0;
    if (uart_data_valid && !mbusy) begin
      mbusy <= 1'b1;
      mcnt  <= 10;
    end else if (mbusy) begin
      if (mcnt == 1) begin
        mbusy        <= 1'b0;
        uart_tx_done <= 1'b1;
      end
      mcnt <= mcnt - 1;
    end
  end

  typedef struct {
    bit         is_done;
    logic [3:0] id;
    logic [7:0] data;
    logic [6:0] addr;
  } sb_t;

  typedef struct {
    logic [3:0] req;
    int         n;
    int         order [2];
  } vec_t;

  sb_t        sbq [$];
  logic [3:0] done_log [$];
  sb_t        e;
  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  bit         sb_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (uart_data_valid) begin
        strobe_cnt++;
        if (sb_en) begin
          if (sbq.size() == 0) begin
            chk("sb_extra_strobe", 32'(uart_data), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("sb_kind_strobe", 32'(e.is_done), 32'd0);
            chk("sb_data", 32'(uart_data), 32'(e.data));
            chk("sb_addr", 32'(rom_addr), 32'(e.addr));
            chk("sb_grant", 32'(grant), 32'(e.id));
          end
        end
      end
      if (msg_done != 4'b0) begin
        done_log.push_back(msg_done);
        if (sb_en) begin
          if (sbq.size() == 0) begin
            chk("sb_extra_done", 32'(msg_done), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("sb_kind_done", 32'(e.is_done), 32'd1);
            chk("sb_done_id", 32'(msg_done), 32'(e.id));
          end
        end
      end
    end
  end

  task automatic push_msg(input int id);
    sb_t r;
    for (int i = 0; i < 32; i++) begin
      if (rom_img[id*32+i] == 8'h00) break;
      r.is_done = 1'b0;
      r.id      = 4'b0001 << id;
      r.data    = rom_img[id*32+i];
      r.addr    = 7'(id*32 + i);
      sbq.push_back(r);
    end
    r.is_done = 1'b1;
    r.id      = 4'b0001 << id;
    r.data    = '0;
    r.addr    = '0;
    sbq.push_back(r);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sbq.size() != 0 || busy) && n < lim);
    chk(nm, 32'(sbq.size() == 0 && !busy), 32'd1);
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        32'({grant, msg_done, busy, uart_data_valid, uart_data, rom_addr}),
        32'd0);
    rst = 1'b0;
  endtask

  vec_t tbl [4];

  initial begin
    int lat;
    int glat;
    int bad;
    int s0;

    for (int i = 0; i < 128; i++) rom_img[i] = 8'h00;
    rom_img[0] = 8'h41; rom_img[1] = 8'h42; rom_img[2] = 8'h43;
    for (int i = 0; i < 32; i++) rom_img[32+i] = 8'(8'h80 + i);
    rom_img[64] = 8'h51; rom_img[65] = 8'h52;

    tbl[0] = '{4'b0101, 2, '{0, 2}};
    tbl[1] = '{4'b1001, 2, '{3, 0}};
    tbl[2] = '{4'b0010, 1, '{1, 0}};
    tbl[3] = '{4'b0110, 2, '{2, 1}};

    repeat (3) @(negedge clk);
    do_reset();

    // single request: latency to first strobe
    push_msg(0);
    @(negedge clk);
    req = 4'b0001;
    lat = 0;
    do begin
      @(negedge clk);
      req = '0;
      lat++;
    end while (!uart_data_valid && lat < 20);
    chk("first_strobe_latency", 32'(lat), 32'd5);
    wait_drain(200, "single_drain");
    chk("single_idle_grant", 32'(grant), 32'd0);

    // empty message: no strobe, done 3 cycles after grant
    push_msg(3);
    s0 = strobe_cnt;
    @(negedge clk);
    req = 4'b1000;
    lat = 0;
    glat = 0;
    do begin
      @(negedge clk);
      req = '0;
      lat++;
      if (glat == 0 && grant == 4'b1000) glat = lat;
    end while (msg_done == 4'b0 && lat < 20);
    chk("empty_grant_latency", 32'(glat), 32'd2);
    chk("empty_done_latency", 32'(lat), 32'd5);
    wait_drain(50, "empty_drain");
    chk("empty_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < tbl[v].n; k++) push_msg(tbl[v].order[k]);
      pulse(tbl[v].req);
      wait_drain(2000, "table_drain");
    end

    // UART busy stall in SEND
    hold_busy = 1'b1;
    push_msg(2);
    s0 = strobe_cnt;
    pulse(4'b0100);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 4 && uart_data != 8'h51) bad++;
    end
    chk("stall_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("stall_data_stable", 32'(bad), 32'd0);
    chk("stall_grant", 32'(grant), 32'b0100);
    chk("stall_busy", 32'(busy), 32'd1);
    hold_busy = 1'b0;
    wait_drain(200, "stall_drain");

    // reset during WAIT_DONE of byte 2
    sb_en = 1'b0;
    s0 = strobe_cnt;
    pulse(4'b0001);
    lat = 0;
    while (strobe_cnt - s0 < 2 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("midmsg_reached_byte2", 32'(strobe_cnt - s0), 32'd2);
    @(negedge clk);
    done_log.delete();
    do_reset();
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    chk("midmsg_no_done", 32'(done_log.size()), 32'd0);
    chk("midmsg_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    sb_en = 1'b1;
    push_msg(0);
    pulse(4'b0001);
    wait_drain(200, "restart_drain");

    // fairness with requests held high
    do_reset();
    sb_en = 1'b0;
    done_log.delete();
    @(negedge clk);
    req = 4'b1111;
    lat = 0;
    while (done_log.size() < 5 && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    req = '0;
    chk("fair_count", 32'(done_log.size() >= 5), 32'd1);
    if (done_log.size() >= 5) begin
      chk("fair_0", 32'(done_log[0]), 32'b0001);
      chk("fair_1", 32'(done_log[1]), 32'b0010);
      chk("fair_2", 32'(done_log[2]), 32'b0100);
      chk("fair_3", 32'(done_log[3]), 32'b1000);
      chk("fair_4", 32'(done_log[4]), 32'b0001);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
